// File: rtl/cross_bar_rtn_pkg.sv
// Shared constants and types for the mcash crossbar return path.
//   NUM_CH     : number of mcash channels served (ids 0..2, id 3 is illegal)
//   ROB_DEPTH  : reorder slots per channel (power of two), ROB_W = log2
//   DATA_W     : return beat width
package cross_bar_rtn_pkg;
  localparam int NUM_CH    = 3;
  localparam int ROB_DEPTH = 4;
  localparam int ROB_W     = 2;
  localparam int DATA_W    = 128;

  typedef enum logic [1:0] {
    CH0        = 2'd0,
    CH1        = 2'd1,
    CH2        = 2'd2,
    CH_ILLEGAL = 2'd3
  } ch_id_e;

  typedef struct packed {
    ch_id_e             ch_id;
    logic [ROB_W-1:0]   rob_num;
    logic [DATA_W-1:0]  data;
  } rtn_beat_t;
endpackage

// File: rtl/cross_bar_rtn_if.sv
// Return-path bus: storage-controller beat input plus the three in-order
// channel return ports.
//   slave  : crossbar view (consumes sc beats, produces channel returns)
//   master : environment view (sc side + channel consumers)
interface cross_bar_rtn_if;
  import cross_bar_rtn_pkg::*;

  logic              sc_xbar_valid_i;
  logic              sc_xbar_ready_o;
  logic [1:0]        sc_xbar_ch_id_i;
  logic [ROB_W-1:0]  sc_xbar_rob_num_i;
  logic [DATA_W-1:0] sc_xbar_data_i;

  logic              mcash_ch0_rtn_valid_o;
  logic              mcash_ch0_rtn_ready_i;
  logic [DATA_W-1:0] mcash_ch0_rtn_data_o;
  logic              mcash_ch1_rtn_valid_o;
  logic              mcash_ch1_rtn_ready_i;
  logic [DATA_W-1:0] mcash_ch1_rtn_data_o;
  logic              mcash_ch2_rtn_valid_o;
  logic              mcash_ch2_rtn_ready_i;
  logic [DATA_W-1:0] mcash_ch2_rtn_data_o;

  modport slave (
    input  sc_xbar_valid_i, sc_xbar_ch_id_i, sc_xbar_rob_num_i, sc_xbar_data_i,
    output sc_xbar_ready_o,
    output mcash_ch0_rtn_valid_o, mcash_ch0_rtn_data_o,
    output mcash_ch1_rtn_valid_o, mcash_ch1_rtn_data_o,
    output mcash_ch2_rtn_valid_o, mcash_ch2_rtn_data_o,
    input  mcash_ch0_rtn_ready_i, mcash_ch1_rtn_ready_i, mcash_ch2_rtn_ready_i
  );

  modport master (
    output sc_xbar_valid_i, sc_xbar_ch_id_i, sc_xbar_rob_num_i, sc_xbar_data_i,
    input  sc_xbar_ready_o,
    input  mcash_ch0_rtn_valid_o, mcash_ch0_rtn_data_o,
    input  mcash_ch1_rtn_valid_o, mcash_ch1_rtn_data_o,
    input  mcash_ch2_rtn_valid_o, mcash_ch2_rtn_data_o,
    output mcash_ch0_rtn_ready_i, mcash_ch1_rtn_ready_i, mcash_ch2_rtn_ready_i
  );
endinterface

// File: rtl/cross_bar_rtn_rob.sv
// Single-channel reorder buffer. Beats land in slot wr_idx_i; only the head
// slot is ever presented, and it retires on valid & ready.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   wr_en_i/idx_i/data_i   : slot write (caller guarantees slot is free)
//   look_idx_i/look_occ_o  : occupancy lookup for the accept decision
//   rtn_valid_o/ready_i/data_o : in-order release port (data 0 when idle)
module cross_bar_rtn_rob
  import cross_bar_rtn_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ROB_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ROB_W-1:0]  look_idx_i,
  output logic              look_occ_o,
  output logic              rtn_valid_o,
  input  logic              rtn_ready_i,
  output logic [DATA_W-1:0] rtn_data_o
);
  logic [ROB_DEPTH-1:0]             occ_q, occ_d;
  logic [ROB_DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [ROB_W-1:0]                 head_q, head_d;
  logic                             rel;

  assign look_occ_o  = occ_q[look_idx_i];
  assign rtn_valid_o = occ_q[head_q];
  assign rtn_data_o  = rtn_valid_o ? data_q[head_q] : '0;
  assign rel         = rtn_valid_o & rtn_ready_i;

  // Release clears first, then write sets; the write slot is never the
  // occupied head, so both take effect when they coincide.
  always_comb begin
    occ_d  = occ_q;
    data_d = data_q;
    head_d = head_q;
    if (rel) begin
      occ_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;  // natural wrap at ROB_DEPTH
    end
    if (wr_en_i) begin
      occ_d[wr_idx_i]  = 1'b1;
      data_d[wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q  <= '0;
      data_q <= '0;
      head_q <= '0;
    end else begin
      occ_q  <= occ_d;
      data_q <= data_d;
      head_q <= head_d;
    end
  end
endmodule

// File: rtl/cross_bar_rtn.sv
// Crossbar return path: steers storage-controller read-return beats into
// one reorder buffer per mcash channel and releases them in ROB order.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   bus (slave)    : sc beat input and channel 0..2 return ports
//   xbar_rtn_err_o : sticky flag, a beat with illegal ch_id 3 was accepted
module cross_bar_rtn
  import cross_bar_rtn_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  cross_bar_rtn_if.slave   bus,
  output logic             xbar_rtn_err_o
);
  logic [NUM_CH-1:0]             wr_en, look_occ, rtn_valid, rtn_ready;
  logic [NUM_CH-1:0][DATA_W-1:0] rtn_data;
  logic [NUM_CH:0]               occ_pad;
  logic                          illegal, acc, err_q;

  assign illegal = (bus.sc_xbar_ch_id_i == CH_ILLEGAL);
  // Padding makes the ch_id index cover all four codes; code 3 reads 0.
  assign occ_pad = {1'b0, look_occ};
  // Illegal beats are always accepted (and dropped) so sc never wedges.
  assign bus.sc_xbar_ready_o = illegal | ~occ_pad[bus.sc_xbar_ch_id_i];
  assign acc = bus.sc_xbar_valid_i & bus.sc_xbar_ready_o;

  assign rtn_ready = {bus.mcash_ch2_rtn_ready_i, bus.mcash_ch1_rtn_ready_i,
                      bus.mcash_ch0_rtn_ready_i};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_en[g] = acc & (bus.sc_xbar_ch_id_i == 2'(g));
    cross_bar_rtn_rob u_rob (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wr_en_i     (wr_en[g]),
      .wr_idx_i    (bus.sc_xbar_rob_num_i),
      .wr_data_i   (bus.sc_xbar_data_i),
      .look_idx_i  (bus.sc_xbar_rob_num_i),
      .look_occ_o  (look_occ[g]),
      .rtn_valid_o (rtn_valid[g]),
      .rtn_ready_i (rtn_ready[g]),
      .rtn_data_o  (rtn_data[g])
    );
  end

  assign bus.mcash_ch0_rtn_valid_o = rtn_valid[0];
  assign bus.mcash_ch0_rtn_data_o  = rtn_data[0];
  assign bus.mcash_ch1_rtn_valid_o = rtn_valid[1];
  assign bus.mcash_ch1_rtn_data_o  = rtn_data[1];
  assign bus.mcash_ch2_rtn_valid_o = rtn_valid[2];
  assign bus.mcash_ch2_rtn_data_o  = rtn_data[2];

  always_ff @(posedge clk_i) begin
    if (rst_i)              err_q <= 1'b0;
    else if (acc & illegal) err_q <= 1'b1;
  end
  assign xbar_rtn_err_o = err_q;
endmodule

// File: tb/tb_cross_bar_rtn.sv
module tb_cross_bar_rtn;
  import cross_bar_rtn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [DATA_W-1:0] exp_q [NUM_CH][$];

  cross_bar_rtn_if bus();

  cross_bar_rtn dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .xbar_rtn_err_o (err)
  );

  always #5 clk = ~clk;

  logic [NUM_CH-1:0]             tv, tr;
  logic [NUM_CH-1:0][DATA_W-1:0] td;
  assign tv = {bus.mcash_ch2_rtn_valid_o, bus.mcash_ch1_rtn_valid_o, bus.mcash_ch0_rtn_valid_o};
  assign tr = {bus.mcash_ch2_rtn_ready_i, bus.mcash_ch1_rtn_ready_i, bus.mcash_ch0_rtn_ready_i};
  assign td = {bus.mcash_ch2_rtn_data_o, bus.mcash_ch1_rtn_data_o, bus.mcash_ch0_rtn_data_o};

  // Scoreboard monitor: sampled mid-cycle, a valid & ready pair is the
  // transfer that completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tv[c] && tr[c]) begin
          n_chk++;
          if (exp_q[c].size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected ch%0d got %h, expected no beat", c, td[c]);
          end else begin
            logic [DATA_W-1:0] e;
            e = exp_q[c].pop_front();
            if (td[c] !== e) begin
              n_fail++;
              $display("FAIL sb_data ch%0d got %h expected %h", c, td[c], e);
            end
          end
        end else if (!tv[c]) begin
          n_chk++;
          if (td[c] !== '0) begin
            n_fail++;
            $display("FAIL idle_data ch%0d got %h expected 0", c, td[c]);
          end
        end
      end
    end
  end

  task automatic drive_idle();
    bus.sc_xbar_valid_i   = 1'b0;
    bus.sc_xbar_ch_id_i   = 2'd0;
    bus.sc_xbar_rob_num_i = '0;
    bus.sc_xbar_data_i    = '0;
  endtask

  // Present a beat and hold it until accepted; returns 1 time unit after
  // the accepting edge with valid dropped.
  task automatic send_beat(input logic [1:0] ch, input logic [ROB_W-1:0] rob,
                           input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    bus.sc_xbar_valid_i   = 1'b1;
    bus.sc_xbar_ch_id_i   = ch;
    bus.sc_xbar_rob_num_i = rob;
    bus.sc_xbar_data_i    = d;
    #1;
    while (!bus.sc_xbar_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout ch%0d rob%0d ready stuck 0, expected 1", ch, rob);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.mcash_ch0_rtn_ready_i = 1'b0;
    bus.mcash_ch1_rtn_ready_i = 1'b0;
    bus.mcash_ch2_rtn_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (tv !== 3'b000) begin n_fail++; $display("FAIL reset_valid got %b expected 000", tv); end
    n_chk++;
    if (td !== '0) begin n_fail++; $display("FAIL reset_data got nonzero expected 0"); end
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", err); end
    n_chk++;
    if (bus.sc_xbar_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b expected 1", bus.sc_xbar_ready_o); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_in_order();
    logic [DATA_W-1:0] d;
    bus.mcash_ch0_rtn_ready_i = 1'b1;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      d = DATA_W'(8'hA0 + i);
      exp_q[0].push_back(d);
      send_beat(2'd0, ROB_W'(i), d);
      if (i == 0) begin
        n_chk++;
        if (tv[0] !== 1'b1 || td[0] !== DATA_W'(8'hA0)) begin
          n_fail++;
          $display("FAIL inorder_latency valid=%b data=%h expected valid=1 data=a0", tv[0], td[0]);
        end
      end
    end
    wait_cycles(3);
    n_chk++;
    if (exp_q[0].size() != 0) begin n_fail++; $display("FAIL inorder_drain left %0d expected 0", exp_q[0].size()); end
  endtask

  task automatic test_reorder();
    bus.mcash_ch1_rtn_ready_i = 1'b1;
    exp_q[1].push_back(DATA_W'(8'hB0));
    exp_q[1].push_back(DATA_W'(8'hB1));
    exp_q[1].push_back(DATA_W'(8'hB2));
    send_beat(2'd1, 2'd2, DATA_W'(8'hB2));
    n_chk++;
    if (tv[1] !== 1'b0) begin n_fail++; $display("FAIL reorder_hold1 valid=%b expected 0", tv[1]); end
    send_beat(2'd1, 2'd1, DATA_W'(8'hB1));
    n_chk++;
    if (tv[1] !== 1'b0) begin n_fail++; $display("FAIL reorder_hold2 valid=%b expected 0", tv[1]); end
    send_beat(2'd1, 2'd0, DATA_W'(8'hB0));
    n_chk++;
    if (tv[1] !== 1'b1 || td[1] !== DATA_W'(8'hB0)) begin
      n_fail++; $display("FAIL reorder_head valid=%b data=%h expected valid=1 data=b0", tv[1], td[1]);
    end
    wait_cycles(4);
    n_chk++;
    if (exp_q[1].size() != 0) begin n_fail++; $display("FAIL reorder_drain left %0d expected 0", exp_q[1].size()); end
  endtask

  task automatic test_backpressure_wrap();
    bus.mcash_ch2_rtn_ready_i = 1'b0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      exp_q[2].push_back(DATA_W'(8'hC0 + i));
      send_beat(2'd2, ROB_W'(i), DATA_W'(8'hC0 + i));
    end
    bus.sc_xbar_valid_i   = 1'b1;
    bus.sc_xbar_ch_id_i   = 2'd2;
    bus.sc_xbar_rob_num_i = 2'd0;
    bus.sc_xbar_data_i    = DATA_W'(8'hC4);
    #1;
    n_chk++;
    if (bus.sc_xbar_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b expected 0", bus.sc_xbar_ready_o); end
    @(posedge clk); #1;
    n_chk++;
    if (tv[2] !== 1'b1 || td[2] !== DATA_W'(8'hC0)) begin
      n_fail++; $display("FAIL bp_stall_hold valid=%b data=%h expected valid=1 data=c0", tv[2], td[2]);
    end
    bus.mcash_ch2_rtn_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.mcash_ch2_rtn_ready_i = 1'b0;
    #1;
    n_chk++;
    if (bus.sc_xbar_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_freed_ready got %b expected 1", bus.sc_xbar_ready_o); end
    exp_q[2].push_back(DATA_W'(8'hC4));
    @(posedge clk); #1;
    drive_idle();
    n_chk++;
    if (tv[2] !== 1'b1 || td[2] !== DATA_W'(8'hC1)) begin
      n_fail++; $display("FAIL bp_next_head valid=%b data=%h expected valid=1 data=c1", tv[2], td[2]);
    end
    bus.mcash_ch2_rtn_ready_i = 1'b1;
    wait_cycles(6);
    n_chk++;
    if (exp_q[2].size() != 0 || tv[2] !== 1'b0) begin
      n_fail++; $display("FAIL bp_wrap_drain left %0d valid=%b expected 0 and 0", exp_q[2].size(), tv[2]);
    end
  endtask

  task automatic test_illegal();
    bus.sc_xbar_valid_i   = 1'b1;
    bus.sc_xbar_ch_id_i   = 2'd3;
    bus.sc_xbar_rob_num_i = 2'd1;
    bus.sc_xbar_data_i    = DATA_W'(16'hDEAD);
    #1;
    n_chk++;
    if (bus.sc_xbar_ready_o !== 1'b1) begin n_fail++; $display("FAIL illegal_ready got %b expected 1", bus.sc_xbar_ready_o); end
    @(posedge clk); #1;
    drive_idle();
    n_chk++;
    if (err !== 1'b1 || tv !== 3'b000) begin
      n_fail++; $display("FAIL illegal_err err=%b valid=%b expected err=1 valid=000", err, tv);
    end
    wait_cycles(3);
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky err=%b expected 1", err); end
  endtask

  task automatic test_independence_reset();
    bus.mcash_ch0_rtn_ready_i = 1'b0;
    bus.mcash_ch1_rtn_ready_i = 1'b1;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      exp_q[0].push_back(DATA_W'(8'hD0 + i));
      send_beat(2'd0, ROB_W'(i), DATA_W'(8'hD0 + i));
    end
    // ch1 head sits at 3 after the reorder test; rob 0 follows it on wrap.
    exp_q[1].push_back(DATA_W'(8'hE3));
    exp_q[1].push_back(DATA_W'(8'hE0));
    send_beat(2'd1, 2'd3, DATA_W'(8'hE3));
    send_beat(2'd1, 2'd0, DATA_W'(8'hE0));
    wait_cycles(3);
    n_chk++;
    if (exp_q[1].size() != 0) begin n_fail++; $display("FAIL indep_ch1 left %0d expected 0", exp_q[1].size()); end
    n_chk++;
    if (tv[0] !== 1'b1 || td[0] !== DATA_W'(8'hD0)) begin
      n_fail++; $display("FAIL indep_ch0_hold valid=%b data=%h expected valid=1 data=d0", tv[0], td[0]);
    end
    bus.sc_xbar_rob_num_i = 2'd2;
    #1;
    n_chk++;
    if (bus.sc_xbar_ready_o !== 1'b0) begin n_fail++; $display("FAIL indep_full_ready got %b expected 0", bus.sc_xbar_ready_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q[0].delete();
    n_chk++;
    if (tv !== 3'b000 || td !== '0 || err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state valid=%b err=%b expected valid=000 err=0", tv, err);
    end
    n_chk++;
    if (bus.sc_xbar_ready_o !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b expected 1", bus.sc_xbar_ready_o); end
    rst = 1'b0;
    // ch1 head was 1 before reset; rob 0 only releases if head returned to 0.
    exp_q[1].push_back(DATA_W'(8'hF1));
    send_beat(2'd1, 2'd0, DATA_W'(8'hF1));
    n_chk++;
    if (tv[1] !== 1'b1 || td[1] !== DATA_W'(8'hF1)) begin
      n_fail++; $display("FAIL midreset_head valid=%b data=%h expected valid=1 data=f1", tv[1], td[1]);
    end
    wait_cycles(3);
    n_chk++;
    if (exp_q[1].size() != 0 || tv !== 3'b000) begin
      n_fail++; $display("FAIL final_drain left %0d valid=%b expected 0 and 000", exp_q[1].size(), tv);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reorder();
    test_backpressure_wrap();
    test_illegal();
    test_independence_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached, expected test completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cross_bar_rtn.md
# cross_bar_rtn

Return-path half of the mcash crossbar: accepts read-return beats from the storage controller (sc >> xbar), reorders them per channel by ROB number, and delivers them in order to channels 0–2 over valid/ready return interfaces. Sits between the storage controller and the three mcash channel ports, mirroring the request path that issues to the HTU and write buffer. One reorder buffer per channel, so a stalled channel never blocks returns to the other two.

## Interface
- ROB_DEPTH, 4, reorder slots per channel (power of two)
- ROB_W, 2, log2(ROB_DEPTH); width of ROB number
- DATA_W, 128, return beat width

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  reset; synchronous, active-high
- sc_xbar_valid_i  in  1  return beat valid
- sc_xbar_ready_o  out  1  return beat accepted when valid & ready
- sc_xbar_ch_id_i  in  2  destination channel (0–2; 3 illegal)
- sc_xbar_rob_num_i  in  ROB_W  reorder slot of beat within channel
- sc_xbar_data_i  in  DATA_W  return data
- mcash_chN_rtn_valid_o  out  1  (N=0,1,2) in-order return valid
- mcash_chN_rtn_ready_i  in  1  (N=0,1,2) channel accepts return
- mcash_chN_rtn_data_o  out  DATA_W  (N=0,1,2) return data; 0 when valid low
- xbar_rtn_err_o  out  1  sticky: illegal ch_id beat received

## Operation
- Per channel c: ROB_DEPTH slots {occ, data}, head pointer head[c] (ROB_W bits).
- Accept: sc_xbar_ready_o = (ch_id==3) | ~occ[ch_id][rob_num]; combinational from registered occupancy and current ch_id/rob_num only.
- On valid & ready, legal ch_id: slot[ch_id][rob_num] <= {1, data}.
- On valid & ready, ch_id==3: beat dropped, xbar_rtn_err_o <= 1 (held until reset).
- Release: rtn_valid[c] = occ[c][head[c]]; rtn_data[c] = slot data when valid, else 0.
- On rtn_valid & rtn_ready: occ[c][head[c]] <= 0, head[c] <= head[c]+1 modulo ROB_DEPTH (natural ROB_W wrap).
- Out-of-order arrivals wait in slots; only head slot is ever presented.
- Write to an occupied slot is never performed; ready low stalls sc until slot freed.

## Timing
- Reset (rst_i high at clock edge): all occ=0, head=0, slot data=0, err=0. Outputs during/after reset: all rtn_valid 0, rtn_data 0, err 0; sc_xbar_ready_o follows rule (1 for free slots).
- Reset mid-operation discards all buffered beats; no partial release.
- Latency: beat accepted at edge N into head slot -> rtn_valid high in cycle after N (1 cycle). No input-to-output bypass.
- Slot freed at edge N is writable from cycle after N (ready evaluated from registered occ; no same-cycle reuse).
- Simultaneous accept into channel c slot k and release of channel c head slot j≠k: both take effect.
- rtn_valid, once high, stays high with stable data until rtn_ready (AXI-style).
- Channels fully independent; release on all three in the same cycle allowed.

## Structure
- Shared package (mcash xbar pkg): channel count 3, ch_id encoding incl. illegal 3, DATA_W, ROB_DEPTH/ROB_W constants, return beat struct {ch_id, rob_num, data}.
- One sub-module: cross_bar_rtn_rob (single-channel reorder buffer: slot array, head pointer, write port, valid/ready release port, occupancy lookup output); instantiated three times, top decodes ch_id and muxes occupancy for sc_xbar_ready_o.

## Test plan
- In-order: ch0 beats rob 0,1,2,3 data 0xA0..0xA3, ready held 1 -> ch0 rtn 0xA0,0xA1,0xA2,0xA3 on consecutive cycles starting 1 cycle after first accept.
- Reorder: ch1 rob 2 (0xB2), rob 1 (0xB1), rob 0 (0xB0) -> no ch1 valid until rob 0 arrives, then 0xB0,0xB1,0xB2 back-to-back.
- Backpressure/wrap: ch2 ready 0, fill rob 0–3, present rob 0 again -> sc_xbar_ready_o=0; raise ready for one beat -> slot 0 freed, new beat accepted next cycle, head wraps 3->0 and it appears after the other three.
- Illegal id: ch_id=3 valid -> ready=1, no channel valid, xbar_rtn_err_o=1 and stays 1 until rst_i.
- Independence: ch0 ready 0 with full ROB, ch1 beats continue -> ch1 returns unaffected; assert rst_i mid-stream -> all valid 0, heads 0, err 0 next cycle.
